// File: rtl/control_botones_estado_pkg.sv
`default_nettype none
// ============================================================================
// estado_pkg : restart FSM encoding, LED one-hot codes, acknowledge value
// Revision   : 1.0
// ============================================================================
package estado_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ERROR  = 2'd2
  } estado_fsm_e;

  localparam logic [3:0] C_LED_0 = 4'b0001;
  localparam logic [3:0] C_LED_1 = 4'b0010;
  localparam logic [3:0] C_LED_2 = 4'b0100;
  localparam logic [3:0] C_LED_3 = 4'b1000;

  // The sequence machine reports state 0 once it has taken the restart.
  localparam logic [1:0] C_VALOR_ACK = 2'd0;

  function automatic logic [3:0] decode_led(input logic [1:0] valor);
    logic [3:0] led;
    case (valor)
      2'd0:    led = C_LED_0;
      2'd1:    led = C_LED_1;
      2'd2:    led = C_LED_2;
      default: led = C_LED_3;
    endcase
    return led;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_botones_estado_if.sv
`default_nettype none
// ============================================================================
// control_botones_estado_if : buttons, state feedback and control outputs
// Revision                  : 1.0
// ============================================================================
interface control_botones_estado_if;
  import estado_pkg::*;

  logic       iBtnRestart;
  logic       iBtnPause;
  logic [1:0] iValorEstado;
  logic       oRestart;
  logic       oPause;
  logic       oError;
  logic [3:0] oEstadoLed;

  modport master (
    output iBtnRestart, iBtnPause, iValorEstado,
    input  oRestart, oPause, oError, oEstadoLed
  );

  modport slave (
    input  iBtnRestart, iBtnPause, iValorEstado,
    output oRestart, oPause, oError, oEstadoLed
  );
endinterface
`default_nettype wire

// File: rtl/control_botones_estado_antirrebote.sv
`default_nettype none
// ============================================================================
// antirrebote : 2-flop synchroniser, debounce counter, 1-cycle press pulse
// Revision    : 1.0
// ============================================================================
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_btn,
  output logic      o_press
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q, deb_prev_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d    = i_btn;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    deb_prev_d = deb_q;
    // Only the rising edge of the filtered level is an event.
    press_d    = deb_q & ~deb_prev_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == C_CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_press = press_q;

endmodule
`default_nettype wire

// File: rtl/control_botones_estado.sv
`default_nettype none
// ============================================================================
// control_botones_estado : debounced restart/pause front-end with ack timeout
// Revision               : 1.0
// ============================================================================
module control_botones_estado
  import estado_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RESTART_MIN     = 4,
  parameter int RESTART_TIMEOUT = 1000
) (
  input  wire logic              iClk,
  input  wire logic              iReset,
  control_botones_estado_if.slave bus
);

  localparam int C_MAX_CNT = (DEBOUNCE_CYCLES > RESTART_TIMEOUT) ? DEBOUNCE_CYCLES
                                                                 : RESTART_TIMEOUT;
  localparam int CNT_W = $clog2(C_MAX_CNT + 1);
  localparam logic [CNT_W-1:0] C_HOLD_MIN = CNT_W'(RESTART_MIN - 1);
  localparam logic [CNT_W-1:0] C_HOLD_TO  = CNT_W'(RESTART_TIMEOUT - 1);

  logic press_restart;
  logic press_pause;

  antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_restart (
    .clk     (iClk),
    .rst     (iReset),
    .i_btn   (bus.iBtnRestart),
    .o_press (press_restart)
  );

  antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_pause (
    .clk     (iClk),
    .rst     (iReset),
    .i_btn   (bus.iBtnPause),
    .o_press (press_pause)
  );

  estado_fsm_e      state_q, state_d;
  logic             restart_q, restart_d;
  logic             pause_q, pause_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       led_q, led_d;

  always_comb begin
    state_d    = state_q;
    restart_d  = restart_q;
    pause_d    = pause_q;
    error_d    = error_q;
    hold_cnt_d = hold_cnt_q;
    led_d      = decode_led(bus.iValorEstado);

    case (state_q)
      IDLE, ERROR: begin
        // Restart outranks a same-cycle pause press and always unpauses.
        if (press_restart) begin
          state_d    = ASSERT;
          restart_d  = 1'b1;
          pause_d    = 1'b0;
          error_d    = 1'b0;
          hold_cnt_d = '0;
        end else if (press_pause) begin
          pause_d = ~pause_q;
        end
      end
      ASSERT: begin
        restart_d  = 1'b1;
        hold_cnt_d = hold_cnt_q + 1'b1;
        if ((hold_cnt_q >= C_HOLD_MIN) && (bus.iValorEstado == C_VALOR_ACK)) begin
          state_d    = IDLE;
          restart_d  = 1'b0;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == C_HOLD_TO) begin
          state_d    = ERROR;
          restart_d  = 1'b0;
          error_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        restart_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q    <= IDLE;
      restart_q  <= 1'b0;
      pause_q    <= 1'b0;
      error_q    <= 1'b0;
      hold_cnt_q <= '0;
      led_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      restart_q  <= restart_d;
      pause_q    <= pause_d;
      error_q    <= error_d;
      hold_cnt_q <= hold_cnt_d;
      led_q      <= led_d;
    end
  end

  assign bus.oRestart   = restart_q;
  assign bus.oPause     = pause_q;
  assign bus.oError     = error_q;
  assign bus.oEstadoLed = led_q;

endmodule
`default_nettype wire

// File: tb/tb_control_botones_estado.sv
`default_nettype none
// ============================================================================
// tb_control_botones_estado : scenario bench with expected-output queue
// Revision                  : 1.0
// ============================================================================
module tb_control_botones_estado;

  typedef struct packed {
    logic       restart;
    logic       pause;
    logic       error;
    logic [3:0] led;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [3:0] led_tab [4];

  control_botones_estado_if bus_if ();

  control_botones_estado #(
    .DEBOUNCE_CYCLES (4),
    .RESTART_MIN     (4),
    .RESTART_TIMEOUT (20)
  ) dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, got;
    rst = 1'b1;
    bus_if.iBtnRestart  = 1'b0;
    bus_if.iBtnPause    = 1'b0;
    bus_if.iValorEstado = 2'd2;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b0000});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_init c=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 c, got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bus_if.iBtnRestart = (c < 10);
      exp_q.push_back({(c >= 7), 1'b0, 1'b0, led_tab[bus_if.iValorEstado]});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_enter_assert c=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 c, got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
    end
    rst = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b0000});
    tick();
    rst = 1'b0;
    e = exp_q.pop_front();
    got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL reset_mid_assert got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
               got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
    end
    for (int c = 0; c < 6; c++) begin
      exp_q.push_back({1'b0, 1'b0, 1'b0, led_tab[bus_if.iValorEstado]});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_idle_after c=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 c, got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
    end
  endtask

  task automatic test_debounce_pause();
    exp_t e, got;
    logic [31:0] cv;
    // Bouncing input never survives the filter.
    for (int c = 0; c < 12; c++) begin
      cv = c;
      bus_if.iBtnPause = (c < 4) ? ~cv[0] : 1'b0;
      exp_q.push_back({1'b0, 1'b0, 1'b0, led_tab[bus_if.iValorEstado]});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL pause_bounce c=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 c, got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
    end
    for (int c = 0; c < 18; c++) begin
      bus_if.iBtnPause = (c < 10);
      exp_q.push_back({1'b0, (c >= 7), 1'b0, led_tab[bus_if.iValorEstado]});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL pause_on c=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 c, got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
    end
    for (int c = 0; c < 18; c++) begin
      bus_if.iBtnPause = (c < 10);
      exp_q.push_back({1'b0, (c < 7), 1'b0, led_tab[bus_if.iValorEstado]});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL pause_off c=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 c, got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
    end
  endtask

  task automatic test_restart_ack();
    exp_t e, got;
    bus_if.iValorEstado = 2'd2;
    for (int c = 0; c < 18; c++) begin
      bus_if.iBtnRestart = (c < 10);
      exp_q.push_back({(c >= 7 && c <= 10), 1'b0, 1'b0, led_tab[bus_if.iValorEstado]});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL restart_ack c=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 c, got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
      if (c == 7) bus_if.iValorEstado = 2'd0;
    end
  endtask

  task automatic test_timeout();
    exp_t e, got;
    bus_if.iValorEstado = 2'd2;
    for (int c = 0; c < 30; c++) begin
      bus_if.iBtnRestart = (c < 10);
      exp_q.push_back({(c >= 7 && c <= 26), 1'b0, (c >= 27), led_tab[bus_if.iValorEstado]});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL timeout c=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 c, got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
    end
    for (int c = 0; c < 18; c++) begin
      bus_if.iBtnRestart = (c < 10);
      exp_q.push_back({(c >= 7 && c <= 10), 1'b0, (c < 7), led_tab[bus_if.iValorEstado]});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL error_clear c=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 c, got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
      if (c == 8) bus_if.iValorEstado = 2'd0;
    end
  endtask

  task automatic test_simultaneous();
    exp_t e, got;
    bus_if.iValorEstado = 2'd2;
    for (int c = 0; c < 18; c++) begin
      bus_if.iBtnPause = (c < 10);
      exp_q.push_back({1'b0, (c >= 7), 1'b0, led_tab[bus_if.iValorEstado]});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL simul_pause_set c=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 c, got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
    end
    // Second pause press lands while ASSERT is still holding.
    for (int c = 0; c < 36; c++) begin
      bus_if.iBtnRestart = (c < 10);
      bus_if.iBtnPause   = (c < 10) || (c >= 16 && c < 26);
      exp_q.push_back({(c >= 7 && c <= 26), (c < 7), (c >= 27), led_tab[bus_if.iValorEstado]});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL simul_press c=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 c, got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
    end
  endtask

  task automatic test_led_decode();
    exp_t e, got;
    int   seq [8];
    logic [3:0] prev_led;
    seq = '{0, 1, 2, 3, 3, 2, 1, 0};
    for (int i = 0; i < 8; i++) begin
      bus_if.iValorEstado = 2'(seq[i]);
      exp_q.push_back({1'b0, 1'b0, 1'b1, led_tab[bus_if.iValorEstado]});
      tick();
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL led_decode v=%0d got r/p/e/led=%b/%b/%b/%b want %b/%b/%b/%b",
                 seq[i], got.restart, got.pause, got.error, got.led, e.restart, e.pause, e.error, e.led);
      end
      // Between edges the LEDs must not follow the input.
      prev_led = e.led;
      bus_if.iValorEstado = 2'(3 - seq[i]);
      exp_q.push_back({1'b0, 1'b0, 1'b1, prev_led});
      #1;
      e = exp_q.pop_front();
      got = {bus_if.oRestart, bus_if.oPause, bus_if.oError, bus_if.oEstadoLed};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL led_registered v=%0d got led=%b want %b", seq[i], got.led, e.led);
      end
    end
  endtask

  initial begin
    led_tab[0] = 4'b0001;
    led_tab[1] = 4'b0010;
    led_tab[2] = 4'b0100;
    led_tab[3] = 4'b1000;
    test_reset();
    test_debounce_pause();
    test_restart_ack();
    test_timeout();
    test_simultaneous();
    test_led_decode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/control_botones_estado.md
Name: control_botones_estado

Overview:
Front-end controller that drives the restart/pause inputs of the 2-bit sequence state machine from two raw push-buttons, and watches that machine's 2-bit state value.
- Each button is synchronised and debounced, then converted into a single-cycle press event.
- Pause presses toggle a pause level; restart presses issue a restart pulse held until the state machine acknowledges by reporting state 0.
- The returned state value is decoded to one-hot LEDs.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a debounced button value changes (1 ms at 50 MHz); must be >= 1.
RESTART_MIN, 4, minimum cycles oRestart stays high; must be >= 1.
RESTART_TIMEOUT, 1000, cycles in ASSERT without acknowledge before flagging error; must be > RESTART_MIN.

Ports:
iClk  input  1  single system clock, all logic on rising edge.
iReset  input  1  synchronous, active-high reset.
iBtnRestart  input  1  raw restart button, asynchronous, active-high.
iBtnPause  input  1  raw pause button, asynchronous, active-high.
iValorEstado  input  2  state value returned by the sequence state machine.
oRestart  output  1  restart request to the state machine, active-high level.
oPause  output  1  pause request to the state machine, active-high level.
oError  output  1  sticky flag: restart not acknowledged within RESTART_TIMEOUT.
oEstadoLed  output  4  registered one-hot decode of iValorEstado.

Behaviour:
- Reset (iReset high at a clock edge):
  - oRestart=0, oPause=0, oError=0, oEstadoLed=4'b0000.
  - FSM goes to IDLE; sync flops, debounced values, press pulses and all counters go to 0.
  - Reset has priority over every event, including mid-ASSERT and mid-debounce.
- Synchroniser: 2-flop chain per button.
- Debounce, per button:
  - The counter increments each cycle the synchronised value differs from the debounced value.
  - Any cycle they agree clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value takes the new value and the counter clears.
  - Counter width is clog2(max(DEBOUNCE_CYCLES, RESTART_TIMEOUT)+1).
- Press event: registered 1-cycle pulse on the debounced 0->1 transition. Releases produce no event.
- Latency: from the first edge sampling a stable raw high to the oPause/oRestart change is exactly DEBOUNCE_CYCLES+4 edges.
- Restart FSM, states IDLE, ASSERT, ERROR; 2-bit encoding from the package:
  - IDLE: a restart press moves to ASSERT next edge, sets oRestart=1, clears the hold counter, and forces oPause=0.
  - ASSERT: oRestart=1 and the hold counter increments each cycle.
    - If counter >= RESTART_MIN-1 and iValorEstado==0, go to IDLE with oRestart=0 next edge.
    - Otherwise, if counter reaches RESTART_TIMEOUT-1, go to ERROR with oRestart=0 and oError=1.
    - Acknowledge is checked before timeout; both in the same cycle means acknowledge wins.
  - ERROR: oError stays 1. A restart press goes to ASSERT, clears oError, and forces oPause=0.
- Pause:
  - A press in IDLE or ERROR toggles oPause next edge.
  - Pause presses during ASSERT are dropped.
  - Restart and pause press in the same cycle: restart wins, pause dropped, oPause=0.
  - Restart presses during ASSERT are ignored; the counter is not restarted.
- oEstadoLed: registered, 1-cycle latency. Mapping: 0->0001, 1->0010, 2->0100, 3->1000. Updates every cycle in all FSM states.
- Button held indefinitely: exactly one press event, no auto-repeat.

Decomposition:
- Package estado_pkg:
  - FSM state constants (IDLE=2'd0, ASSERT=2'd1, ERROR=2'd2).
  - LED one-hot constants.
  - State-value constant for the acknowledge state (2'd0).
- Sub-module antirrebote: synchroniser + debounce counter + rising-edge press pulse, parameter DEBOUNCE_CYCLES; instantiated once per button.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, RESTART_MIN=4, RESTART_TIMEOUT=20.
1. Reset: pulse iReset mid-ASSERT -> next edge oRestart=0, oPause=0, oError=0, oEstadoLed=0000, FSM IDLE.
2. Debounce and pause:
   - Bounce iBtnPause 1,0,1,0 on alternate cycles -> oPause stays 0.
   - Hold high 10 cycles -> oPause=1 exactly 8 edges after the stable high.
   - A second clean press -> oPause=0.
3. Restart acknowledge:
   - Press restart with iValorEstado=2 -> oRestart=1.
   - Drive iValorEstado=0 after 1 cycle -> oRestart stays high for 4 cycles total, then 0.
   - oError=0 throughout.
4. Timeout: press restart, hold iValorEstado=2 -> oRestart high 20 cycles, then oRestart=0 and oError=1. A new restart press clears oError and reasserts oRestart.
5. Simultaneous presses: oPause=1, then restart and pause debounced on the same cycle -> oRestart=1, oPause=0. A pause press during ASSERT leaves oPause=0.
6. LED decode: sweep iValorEstado 0,1,2,3 -> oEstadoLed 0001, 0010, 0100, 1000, each one cycle later.
